// File: rtl/ilm_dot_accum.sv
// Dot-product accumulator for the approximate log multiplier product stream.
// Sums 16-bit products per vector, saturates on overflow, and holds the result until accepted.
module ilm_dot_accum #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [15:0]      prod_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic             ready_o,
    output logic [ACC_W-1:0] sum_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic             len_err_o,
    output logic             valid_o,
    input  logic             ready_i
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state;
    logic [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             ovf_acc_p0;

    logic [ACC_W-1:0] sum_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             ovf_p1;
    logic             len_err_p1;
    logic             vld_p1;

    // Returns {overflow, value}; value pins at all-ones once the sum leaves ACC_W bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [15:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - 16){1'b0}}, p};
        if (s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    logic [ACC_W:0]   add_res;
    logic [CNT_W-1:0] cnt_nxt;
    logic             end_vec;

    always_comb begin
        add_res = sat_add(acc_p0, prod_i);
        cnt_nxt = cnt_p0 + 1'b1;
        end_vec = last_i | (cnt_nxt == MAX_CNT);
    end

    assign ready_o   = (state == ACCUM);
    assign sum_o     = sum_p1;
    assign count_o   = cnt_p1;
    assign ovf_o     = ovf_p1;
    assign len_err_o = len_err_p1;
    assign valid_o   = vld_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ACCUM;
            acc_p0     <= '0;
            cnt_p0     <= '0;
            ovf_acc_p0 <= 1'b0;
            sum_p1     <= '0;
            cnt_p1     <= '0;
            ovf_p1     <= 1'b0;
            len_err_p1 <= 1'b0;
            vld_p1     <= 1'b0;
        end else if (clr_i) begin
            state      <= ACCUM;
            acc_p0     <= '0;
            cnt_p0     <= '0;
            ovf_acc_p0 <= 1'b0;
            sum_p1     <= '0;
            cnt_p1     <= '0;
            ovf_p1     <= 1'b0;
            len_err_p1 <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (valid_i) begin
                        if (end_vec) begin
                            // p0 -> p1: terminating beat loads the result register.
                            sum_p1     <= add_res[ACC_W-1:0];
                            cnt_p1     <= cnt_nxt;
                            ovf_p1     <= ovf_acc_p0 | add_res[ACC_W];
                            len_err_p1 <= ~last_i;
                            vld_p1     <= 1'b1;
                            acc_p0     <= '0;
                            cnt_p0     <= '0;
                            ovf_acc_p0 <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            acc_p0     <= add_res[ACC_W-1:0];
                            cnt_p0     <= cnt_nxt;
                            ovf_acc_p0 <= ovf_acc_p0 | add_res[ACC_W];
                        end
                    end
                end
                HOLD: begin
                    if (vld_p1 && ready_i) begin
                        vld_p1 <= 1'b0;
                        state  <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ilm_dot_accum.sv
// Directed bench for ilm_dot_accum: default, narrow-accumulator and short-MAX_LEN instances.
module tb_ilm_dot_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] prod = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        rdy_in = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: defaults (ACC_W=24, MAX_LEN=256)
    logic        a_ready, a_ovf, a_len, a_valid;
    logic [23:0] a_sum;
    logic [15:0] a_cnt;
    ilm_dot_accum u_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .prod_i(prod), .valid_i(valid),
        .last_i(last), .ready_o(a_ready), .sum_o(a_sum), .count_o(a_cnt),
        .ovf_o(a_ovf), .len_err_o(a_len), .valid_o(a_valid), .ready_i(rdy_in));

    // Instance B: 16-bit accumulator for saturation
    logic        b_ready, b_ovf, b_len, b_valid;
    logic [15:0] b_sum;
    logic [15:0] b_cnt;
    ilm_dot_accum #(.ACC_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .prod_i(prod), .valid_i(valid),
        .last_i(last), .ready_o(b_ready), .sum_o(b_sum), .count_o(b_cnt),
        .ovf_o(b_ovf), .len_err_o(b_len), .valid_o(b_valid), .ready_i(rdy_in));

    // Instance C: MAX_LEN=4 for forced termination
    logic        c_ready, c_ovf, c_len, c_valid;
    logic [23:0] c_sum;
    logic [15:0] c_cnt;
    ilm_dot_accum #(.MAX_LEN(4)) u_c (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .prod_i(prod), .valid_i(valid),
        .last_i(last), .ready_o(c_ready), .sum_o(c_sum), .count_o(c_cnt),
        .ovf_o(c_ovf), .len_err_o(c_len), .valid_o(c_valid), .ready_i(rdy_in));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a falling edge; presents one beat for a single rising edge.
    task automatic send(input logic [15:0] p, input logic l);
        valid = 1'b1;
        prod  = p;
        last  = l;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        prod  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sum",   32'(a_sum),   0);
        chk("rst_cnt",   32'(a_cnt),   0);
        chk("rst_ovf",   32'(a_ovf),   0);
        chk("rst_len",   32'(a_len),   0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_ready", 32'(a_ready), 1);

        // Basic three-beat vector
        rdy_in = 1'b1;
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b1);
        chk("t1_valid", 32'(a_valid), 1);
        chk("t1_sum",   32'(a_sum),   600);
        chk("t1_cnt",   32'(a_cnt),   3);
        chk("t1_ovf",   32'(a_ovf),   0);
        chk("t1_len",   32'(a_len),   0);
        chk("t1_ready_low", 32'(a_ready), 0);
        @(negedge clk);
        chk("t1_valid_drop", 32'(a_valid), 0);
        chk("t1_ready_back", 32'(a_ready), 1);

        // Saturation on 16-bit accumulator
        do_reset();
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0005, 1'b1);
        chk("t2_valid", 32'(b_valid), 1);
        chk("t2_sum",   32'(b_sum),   32'hFFFF);
        chk("t2_ovf",   32'(b_ovf),   1);
        chk("t2_cnt",   32'(b_cnt),   3);
        @(negedge clk);
        send(16'd7, 1'b1);
        chk("t2_next_sum", 32'(b_sum), 7);
        chk("t2_next_ovf", 32'(b_ovf), 0);
        chk("t2_next_cnt", 32'(b_cnt), 1);

        // Forced termination at MAX_LEN=4, fifth beat stalls
        do_reset();
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd10, 1'b0);
        chk("t3_valid", 32'(c_valid), 1);
        chk("t3_sum",   32'(c_sum),   40);
        chk("t3_cnt",   32'(c_cnt),   4);
        chk("t3_len",   32'(c_len),   1);
        valid = 1'b1;
        prod  = 16'd10;
        last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_stall_ready", 32'(c_ready), 0);
        chk("t3_stall_cnt",   32'(c_cnt),   4);
        rdy_in = 1'b1;
        @(negedge clk);
        chk("t3_hs_valid", 32'(c_valid), 0);
        chk("t3_hs_ready", 32'(c_ready), 1);
        @(negedge clk);
        valid = 1'b0;
        send(16'd20, 1'b1);
        chk("t3_new_sum", 32'(c_sum), 30);
        chk("t3_new_cnt", 32'(c_cnt), 2);
        chk("t3_new_len", 32'(c_len), 0);

        // Back-pressure
        do_reset();
        rdy_in = 1'b0;
        send(16'd5, 1'b0);
        send(16'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(a_valid), 1);
            chk("t4_hold_sum",   32'(a_sum),   11);
            chk("t4_hold_ready", 32'(a_ready), 0);
            @(negedge clk);
        end
        rdy_in = 1'b1;
        @(negedge clk);
        chk("t4_rel_valid", 32'(a_valid), 0);
        chk("t4_rel_ready", 32'(a_ready), 1);
        chk("t4_rel_sum",   32'(a_sum),   11);

        // Clear mid-vector and in HOLD
        do_reset();
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_clr_valid", 32'(a_valid), 0);
        send(16'd9, 1'b1);
        chk("t5_sum", 32'(a_sum), 9);
        chk("t5_cnt", 32'(a_cnt), 1);
        @(negedge clk);
        send(16'd0, 1'b0);
        send(16'd0, 1'b1);
        chk("t5_zero_cnt", 32'(a_cnt), 2);
        chk("t5_zero_sum", 32'(a_sum), 0);
        rdy_in = 1'b0;
        @(negedge clk);
        send(16'd9, 1'b1);
        chk("t5_hold_valid", 32'(a_valid), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_hclr_valid", 32'(a_valid), 0);
        chk("t5_hclr_sum",   32'(a_sum),   0);
        chk("t5_hclr_cnt",   32'(a_cnt),   0);
        chk("t5_hclr_ready", 32'(a_ready), 1);

        // Asynchronous reset in HOLD
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b1);
        chk("t6_pre_sum", 32'(a_sum), 600);
        #2 rst = 1'b1;
        #1;
        chk("t6_sum",   32'(a_sum),   0);
        chk("t6_cnt",   32'(a_cnt),   0);
        chk("t6_valid", 32'(a_valid), 0);
        chk("t6_ready", 32'(a_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
